// File: rtl/fisc_useq_if.sv
// Bus interface for the FISC microsequencer: databus, sequencing controls and the decode-side outputs.
// The slave modport is the sequencer's own view; the master modport is the view of whatever drives it.
interface fisc_useq_if #(
    parameter int IR_WIDTH    = 8,
    parameter int PHASE_WIDTH = 4,
    parameter int WAIT_WIDTH  = 3
);
    logic [IR_WIDTH-1:0]             databus;
    logic                            ir_load;
    logic                            useq_reset;
    logic                            mem_slow;
    logic [WAIT_WIDTH-1:0]           wait_states;
    logic                            halt_req;
    logic                            step;
    logic [IR_WIDTH-1:0]             IRval;
    logic [PHASE_WIDTH-1:0]          uSval;
    logic [IR_WIDTH+PHASE_WIDTH-1:0] decode_index;
    logic                            stall;
    logic                            halted;
    logic                            phase_ovf;

    modport slave (
        input  databus, ir_load, useq_reset, mem_slow, wait_states, halt_req, step,
        output IRval, uSval, decode_index, stall, halted, phase_ovf
    );

    modport master (
        output databus, ir_load, useq_reset, mem_slow, wait_states, halt_req, step,
        input  IRval, uSval, decode_index, stall, halted, phase_ovf
    );
endinterface

// File: rtl/fisc_useq.sv
// FISC microsequencer and instruction register with wait states, boundary halt and sticky phase overflow.
// Optional single-step out of HALT is enabled by defining FISC_USEQ_SINGLESTEP_EN.
module fisc_useq #(
    parameter int                  IR_WIDTH    = 8,
    parameter int                  PHASE_WIDTH = 4,
    parameter int                  WAIT_WIDTH  = 3,
    parameter logic [IR_WIDTH-1:0] RESET_IR    = '0
) (
    input  logic       i_clk,
    input  logic       reset,
    fisc_useq_if.slave bus
);
    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_t;

    state_t                 state, state_n;
    logic [IR_WIDTH-1:0]    ir, ir_n;
    logic [PHASE_WIDTH-1:0] phase, phase_n;
    logic [WAIT_WIDTH-1:0]  cnt, cnt_n;
    logic                   done, done_n;
    logic                   ovf, ovf_n;
    logic                   credit, credit_n;
    logic                   start_wait;

    assign start_wait = (state == ST_RUN) && bus.mem_slow && !done && (bus.wait_states != '0);

    always_ff @(posedge i_clk) begin
        if (!reset) begin
            state  <= ST_RUN;
            ir     <= RESET_IR;
            phase  <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            credit <= 1'b0;
        end else begin
            state  <= state_n;
            ir     <= ir_n;
            phase  <= phase_n;
            cnt    <= cnt_n;
            done   <= done_n;
            ovf    <= ovf_n;
            credit <= credit_n;
        end
    end

    always_comb begin
        state_n  = state;
        ir_n     = ir;
        phase_n  = phase;
        cnt_n    = cnt;
        done_n   = done;
        ovf_n    = ovf;
        credit_n = credit;
        case (state)
            ST_RUN: begin
                if (start_wait) begin
                    // A single wait state is served in place; longer waits park in ST_WAIT.
                    if (bus.wait_states == WAIT_WIDTH'(1)) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = ST_WAIT;
                        cnt_n   = bus.wait_states - WAIT_WIDTH'(1);
                    end
                end else begin
                    done_n = 1'b0;
                    if (bus.ir_load) begin
                        ir_n = bus.databus;
                    end
                    if (!bus.useq_reset) begin
                        phase_n  = '0;
                        credit_n = 1'b0;
                        if (bus.halt_req || credit) begin
                            state_n = ST_HALT;
                        end
                    end else begin
                        phase_n = phase + PHASE_WIDTH'(1);
                        if (phase == '1) begin
                            ovf_n = 1'b1;
                        end
                    end
                end
            end
            ST_WAIT: begin
                cnt_n = cnt - WAIT_WIDTH'(1);
                if (cnt == WAIT_WIDTH'(1)) begin
                    state_n = ST_RUN;
                    done_n  = 1'b1;
                end
            end
            ST_HALT: begin
`ifdef FISC_USEQ_SINGLESTEP_EN
                // A step grants exactly one instruction; the next boundary halts again.
                if (bus.step) begin
                    state_n  = ST_RUN;
                    credit_n = 1'b1;
                end else if (!bus.halt_req) begin
                    state_n = ST_RUN;
                end
`else
                if (!bus.halt_req) begin
                    state_n = ST_RUN;
                end
`endif
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase
    end

`ifndef FISC_USEQ_SINGLESTEP_EN
    logic step_unused;
    assign step_unused = bus.step;
`endif

    assign bus.IRval        = ir;
    assign bus.uSval        = phase;
    assign bus.decode_index = {ir, phase};
    assign bus.stall        = start_wait || (state != ST_RUN);
    assign bus.halted       = (state == ST_HALT);
    assign bus.phase_ovf    = ovf;
endmodule

// File: doc/fisc_useq.md
Name: fisc_useq

Overview:
- Parametrised microsequencer and instruction-register front end for the FISC CPU family.
- Replaces the fixed 4-bit phase counter and 8-bit IR pair that drive the decode ROM.
- Generalised in IR and phase width.
- Adds memory wait-state insertion for slow devices, an instruction-boundary halt, and a sticky phase-overflow flag.
- Output decode_index addresses the decode ROM directly.

Parameters:
- IR_WIDTH, 8: instruction register width.
- PHASE_WIDTH, 4: microsequence phase counter width.
- WAIT_WIDTH, 3: width of the wait-state count input.
- RESET_IR, 0: IR value loaded on reset.

Ports:
- i_clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset.
- databus  input  IR_WIDTH  data bus; IR source.
- ir_load  input  1  active high; capture databus into IR on this phase.
- useq_reset  input  1  active low; next phase is 0 (end of instruction).
- mem_slow  input  1  active high; current phase accesses a slow device.
- wait_states  input  WAIT_WIDTH  stall cycles required when mem_slow is high.
- halt_req  input  1  active high; halt at next instruction boundary.
- step  input  1  single-step pulse (see Optional Feature).
- IRval  output  IR_WIDTH  instruction register.
- uSval  output  PHASE_WIDTH  current phase.
- decode_index  output  IR_WIDTH+PHASE_WIDTH  equals {IRval, uSval}.
- stall  output  1  active high; current phase must not commit (control lines gated off).
- halted  output  1  active high; sequencer is in HALT.
- phase_ovf  output  1  sticky; phase counter wrapped without useq_reset.

Behaviour:
- Reset (reset low at an edge):
  - IRval=RESET_IR, uSval=0, state RUN, done=0, wait count cnt=0, phase_ovf=0.
  - Reset has priority over everything, including mid-WAIT and in HALT.
- States: RUN, WAIT, HALT. Internal flag done (current phase's wait already served).
- start_wait = RUN & mem_slow & !done & wait_states!=0.
- stall = start_wait | state==WAIT | state==HALT. stall is combinational from state and inputs.
- RUN with start_wait:
  - No phase advance, no IR load.
  - If wait_states==1: stay RUN, done<=1.
  - Otherwise: state<=WAIT, cnt<=wait_states-1.
- WAIT:
  - cnt<=cnt-1.
  - When cnt==1: state<=RUN, done<=1.
  - Net effect: a phase with N wait states occupies exactly N+1 cycles, N stalled plus 1 executing.
- RUN executing cycle (no start_wait):
  - done<=0.
  - If ir_load: IRval<=databus.
  - If useq_reset low: uSval<=0; else uSval<=uSval+1, modulo 2^PHASE_WIDTH.
  - Wrap from all-ones to 0 without useq_reset sets phase_ovf (sticky until reset).
- Halt:
  - halt_req is sampled only on an executing RUN cycle with useq_reset low (instruction boundary).
  - If high: uSval<=0, state<=HALT.
  - HALT holds IRval and uSval=0; halted=1.
  - halt_req low in HALT: state<=RUN on next edge.
- Simultaneous events:
  - Wait insertion precedes both useq_reset and halt. Both take effect only on the executing cycle.
  - ir_load and useq_reset together: both apply.
  - wait_states changing during WAIT is ignored; it is latched at entry.
- decode_index updates the same cycle as IRval/uSval; no extra latency.

Optional Feature:
- Macro FISC_USEQ_SINGLESTEP_EN.
- Defined:
  - In HALT, step high for one cycle forces state<=RUN with a one-instruction credit.
  - The next instruction boundary re-enters HALT regardless of halt_req, and the credit is consumed.
  - A step asserted outside HALT is ignored.
- Undefined: step port is present but ignored; HALT exits only on halt_req low.

Test Plan:
- Reset then 5 free-running cycles, useq_reset high: uSval 0,1,2,3,4; IRval=0; stall=0; phase_ovf=0.
- databus=8'hA5, ir_load=1 at phase 0, useq_reset low at phase 3: IRval=8'hA5 from phase 1; decode_index=12'hA50 after phase 3 returns to 0.
- mem_slow=1, wait_states=3 at phase 2: stall high for exactly 3 cycles, uSval held at 2, then one executing cycle advances uSval to 3; wait_states=1 gives 1 stall; wait_states=0 gives none.
- halt_req=1 mid-instruction: no halt until the useq_reset-low boundary; then halted=1, uSval=0 held; drop halt_req: resume at phase 0 the next cycle.
- 16 cycles with useq_reset high: uSval wraps 15->0 and phase_ovf=1 stays set; reset low mid-WAIT: next cycle is state RUN, stall=0, phase_ovf=0.
- With FISC_USEQ_SINGLESTEP_EN, halt_req=1 held, step pulse: exactly one instruction (phases until useq_reset low) executes, then halted=1 again.
